// File: rtl/fwd_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Forwarding-select and load-use hazard controller for a 5-stage pipeline.
//   Shadows {valid, rd, reg_write, mem_read} for the instructions in EX, MEM
//   and WB. At each ID->EX advance it registers the 3-bit mux selects for
//   ALU source 1, ALU source 2 and the branch-ALU source so that they line up
//   with the instruction entering EX. A load-use dependency raises stall_o
//   combinationally and a bubble is inserted into EX.
//
//   Select encoding {use_reg, fwd_mem, fwd_wb}:
//     3'b100 register file, 3'b110 MEM forward, 3'b101 WB forward,
//     3'b000 immediate (source 2 only).
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   freeze_i          global hold; no slot or select updates
//   flush_i           squash the ID instruction (bubble into EX)
//   id_*              decoded fields of the instruction in ID
//   stall_o           load-use stall (combinational from current state)
//   ex_src1_sel_o     ALU source 1 select (registered)
//   ex_src2_sel_o     ALU source 2 select (registered)
//   ex_bsrc_sel_o     branch-ALU source select (registered)
//
// Optional build macro
//   FWD_HAZARD_STATS_EN  adds saturating CNT_W-bit statistics counters:
//     stat_fwd_mem_o  advances producing any MEM-forward select
//     stat_fwd_wb_o   advances producing any WB-forward select
//     stat_stall_o    cycles with stall_o=1 and freeze_i=0
// ----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  freeze_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic                  id_use_imm_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    output logic                  stall_o,
    output logic [2:0]            ex_src1_sel_o,
    output logic [2:0]            ex_src2_sel_o,
    output logic [2:0]            ex_bsrc_sel_o
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]      stat_fwd_mem_o,
    output logic [CNT_W-1:0]      stat_fwd_wb_o,
    output logic [CNT_W-1:0]      stat_stall_o
`endif
);

    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_REG = 3'b100;
    localparam logic [SEL_W-1:0] SEL_MEM = 3'b110;
    localparam logic [SEL_W-1:0] SEL_WB  = 3'b101;
    localparam logic [SEL_W-1:0] SEL_IMM = 3'b000;

    // Destination info carried alongside each in-flight instruction
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } slot_t;

    slot_t ex_q,  mem_q,  wb_q;
    slot_t ex_n,  mem_n,  wb_n;
    slot_t id_slot;

    logic [SEL_W-1:0] src1_q, src2_q, bsrc_q;
    logic [SEL_W-1:0] src1_n, src2_n, bsrc_n;

    logic advance;
    logic bubble;
    logic ex_load_hit;

    // True when the slot will write back the register being read
    function automatic logic slot_hit(input slot_t s, input logic [REG_ADDR_W-1:0] rs);
        return s.valid && s.reg_write && (s.rd == rs);
    endfunction

    // Forward-select for one register source; x0 and unused sources read the RF.
    // The EX occupant will be in MEM next cycle, so it wins over the MEM occupant.
    function automatic logic [SEL_W-1:0] fwd_sel(input logic                  used,
                                                 input logic [REG_ADDR_W-1:0] rs,
                                                 input slot_t                 ex_s,
                                                 input slot_t                 mem_s);
        logic [SEL_W-1:0] sel;
        sel = SEL_REG;
        if (used && (rs != '0)) begin
            if (slot_hit(ex_s, rs)) begin
                sel = SEL_MEM;
            end else if (slot_hit(mem_s, rs)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    assign id_slot = '{valid:     id_valid_i,
                       rd:        id_rd_i,
                       reg_write: id_reg_write_i,
                       mem_read:  id_mem_read_i};

    // Load in EX whose result the ID instruction needs next cycle
    assign ex_load_hit = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                         ((id_use_rs1_i && (id_rs1_i == ex_q.rd)) ||
                          (id_use_rs2_i && (id_rs2_i == ex_q.rd)));

    assign stall_o = id_valid_i && ex_load_hit;

    // Freeze overrides both the advance and the flush
    assign advance = !freeze_i;
    assign bubble  = stall_o || flush_i || !id_valid_i;

    // Next-state for shadow slots and registered selects
    always_comb begin
        ex_n   = ex_q;
        mem_n  = mem_q;
        wb_n   = wb_q;
        src1_n = src1_q;
        src2_n = src2_q;
        bsrc_n = bsrc_q;

        if (advance) begin
            wb_n  = mem_q;
            mem_n = ex_q;
            if (bubble) begin
                ex_n   = '0;
                src1_n = SEL_REG;
                src2_n = SEL_REG;
                bsrc_n = SEL_REG;
            end else begin
                ex_n   = id_slot;
                src1_n = fwd_sel(id_use_rs1_i, id_rs1_i, ex_q, mem_q);
                bsrc_n = fwd_sel(id_use_rs2_i, id_rs2_i, ex_q, mem_q);
                src2_n = id_use_imm_i ? SEL_IMM : bsrc_n;
            end
        end
    end

    // Shadow slot and select registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_q   <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            src1_q <= SEL_REG;
            src2_q <= SEL_REG;
            bsrc_q <= SEL_REG;
        end else begin
            ex_q   <= ex_n;
            mem_q  <= mem_n;
            wb_q   <= wb_n;
            src1_q <= src1_n;
            src2_q <= src2_n;
            bsrc_q <= bsrc_n;
        end
    end

    assign ex_src1_sel_o = src1_q;
    assign ex_src2_sel_o = src2_q;
    assign ex_bsrc_sel_o = bsrc_q;

`ifdef FWD_HAZARD_STATS_EN
    logic [CNT_W-1:0] cnt_mem_q, cnt_wb_q, cnt_stall_q;
    logic             inc_mem, inc_wb, inc_stall;

    // Only real advances of a valid instruction count as forwarding events
    assign inc_mem   = advance && !bubble &&
                       ((src1_n == SEL_MEM) || (src2_n == SEL_MEM) || (bsrc_n == SEL_MEM));
    assign inc_wb    = advance && !bubble &&
                       ((src1_n == SEL_WB) || (src2_n == SEL_WB) || (bsrc_n == SEL_WB));
    assign inc_stall = stall_o && !freeze_i;

    // Saturating statistics counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_mem_q   <= '0;
            cnt_wb_q    <= '0;
            cnt_stall_q <= '0;
        end else begin
            if (inc_mem && (cnt_mem_q != '1)) begin
                cnt_mem_q <= cnt_mem_q + CNT_W'(1);
            end
            if (inc_wb && (cnt_wb_q != '1)) begin
                cnt_wb_q <= cnt_wb_q + CNT_W'(1);
            end
            if (inc_stall && (cnt_stall_q != '1)) begin
                cnt_stall_q <= cnt_stall_q + CNT_W'(1);
            end
        end
    end

    assign stat_fwd_mem_o = cnt_mem_q;
    assign stat_fwd_wb_o  = cnt_wb_q;
    assign stat_stall_o   = cnt_stall_q;
`else
    // Counter width only matters when statistics are built in
    logic unused_cnt_w;
    assign unused_cnt_w = CNT_W[0];
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//   Directed bench for fwd_hazard_ctrl. Each step drives one ID instruction,
//   checks the combinational stall, queues the expected registered selects
//   and compares them one clock later.
// ----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       freeze, flush, id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_use_imm, id_reg_write, id_mem_read;
    logic       stall;
    logic [2:0] src1_sel, src2_sel, bsrc_sel;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] st_mem, st_wb, st_stall;
`endif

    typedef struct packed {
        logic [2:0] s1;
        logic [2:0] s2;
        logic [2:0] b;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .CLK            (clk),
        .RST            (rst),
        .freeze_i       (freeze),
        .flush_i        (flush),
        .id_valid_i     (id_valid),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_use_rs1_i   (id_use_rs1),
        .id_use_rs2_i   (id_use_rs2),
        .id_use_imm_i   (id_use_imm),
        .id_rd_i        (id_rd),
        .id_reg_write_i (id_reg_write),
        .id_mem_read_i  (id_mem_read),
        .stall_o        (stall),
        .ex_src1_sel_o  (src1_sel),
        .ex_src2_sel_o  (src2_sel),
        .ex_bsrc_sel_o  (bsrc_sel)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .stat_fwd_mem_o (st_mem),
        .stat_fwd_wb_o  (st_wb),
        .stat_stall_o   (st_stall)
`endif
    );

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_sels(input string tag, input exp_t e);
        chk({tag, ".src1"}, src1_sel, e.s1);
        chk({tag, ".src2"}, src2_sel, e.s2);
        chk({tag, ".bsrc"}, bsrc_sel, e.b);
    endtask

    // One ID instruction: drive, check stall, queue expected selects, clock, compare
    task automatic step(input string      tag,
                        input logic       v,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic       u1,  input logic u2, input logic imm,
                        input logic [4:0] rd,  input logic rw, input logic mr,
                        input logic       fl,  input logic fz,
                        input logic       e_stall,
                        input logic [2:0] e1, input logic [2:0] e2, input logic [2:0] eb);
        exp_t e;
        id_valid = v;  id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_use_imm = imm;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
        flush = fl; freeze = fz;
        #1;
        chk({tag, ".stall"}, {2'b00, stall}, {2'b00, e_stall});
        sb.push_back('{s1: e1, s2: e2, b: eb});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            chk_sels(tag, e);
        end
    endtask

    initial begin
        freeze = 0; flush = 0; id_valid = 0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_use_imm = 0;
        id_reg_write = 0; id_mem_read = 0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("reset.stall", {2'b00, stall}, 3'b000);
        chk_sels("reset", '{s1: 3'b100, s2: 3'b100, b: 3'b100});
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        //    tag          v rs1 rs2 u1 u2 im rd rw mr fl fz st  src1    src2    bsrc
        // Back-to-back: add x5,x1,x2 ; sub x6,x5,x3
        step("add5",      1, 1,  2,  1, 1, 0, 5, 1, 0, 0, 0, 0, 3'b100, 3'b100, 3'b100);
        step("sub6",      1, 5,  3,  1, 1, 0, 6, 1, 0, 0, 0, 0, 3'b110, 3'b100, 3'b100);
        step("nop_a",     1, 0,  0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 3'b100, 3'b000, 3'b100);
        // One-instruction gap: add x5 ; nop ; or x7,x3,x5
        step("add5_b",    1, 1,  2,  1, 1, 0, 5, 1, 0, 0, 0, 0, 3'b100, 3'b100, 3'b100);
        step("nop_b",     1, 0,  0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 3'b100, 3'b000, 3'b100);
        step("or7",       1, 3,  5,  1, 1, 0, 7, 1, 0, 0, 0, 0, 3'b100, 3'b101, 3'b101);
        // Double match: add x5 twice, then and x10,x5,x5 -> MEM wins
        step("add5_c",    1, 1,  2,  1, 1, 0, 5, 1, 0, 0, 0, 0, 3'b100, 3'b100, 3'b100);
        step("add5_d",    1, 1,  2,  1, 1, 0, 5, 1, 0, 0, 0, 0, 3'b100, 3'b100, 3'b100);
        step("and10",     1, 5,  5,  1, 1, 0,10, 1, 0, 0, 0, 0, 3'b110, 3'b110, 3'b110);
        // Load-use: lw x4,0(x1) ; add x8,x4,x4 (stall one cycle, then WB forward)
        step("lw4",       1, 1,  0,  1, 0, 1, 4, 1, 1, 0, 0, 0, 3'b100, 3'b000, 3'b100);
        step("add8_stl",  1, 4,  4,  1, 1, 0, 8, 1, 0, 0, 0, 1, 3'b100, 3'b100, 3'b100);
        step("add8",      1, 4,  4,  1, 1, 0, 8, 1, 0, 0, 0, 0, 3'b101, 3'b101, 3'b101);
        // Load-use with immediate: lw x4,0(x1) ; addi x9,x4,3
        step("lw4_b",     1, 1,  0,  1, 0, 1, 4, 1, 1, 0, 0, 0, 3'b100, 3'b000, 3'b100);
        step("addi9_stl", 1, 4,  3,  1, 0, 1, 9, 1, 0, 0, 0, 1, 3'b100, 3'b100, 3'b100);
        step("addi9",     1, 4,  3,  1, 0, 1, 9, 1, 0, 0, 0, 0, 3'b101, 3'b000, 3'b100);
        // Destination x0: addi x0,x0,1 ; add x11,x0,x0
        step("addi_x0",   1, 0,  0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 3'b100, 3'b000, 3'b100);
        step("add11",     1, 0,  0,  1, 1, 0,11, 1, 0, 0, 0, 0, 3'b100, 3'b100, 3'b100);
        // Freeze overrides flush and holds slots; then the held EX producer forwards
        step("sub12_frz", 1,11,  0,  1, 1, 0,12, 1, 0, 1, 1, 0, 3'b100, 3'b100, 3'b100);
        step("sub12",     1,11,  0,  1, 1, 0,12, 1, 0, 0, 0, 0, 3'b110, 3'b100, 3'b100);
        step("hold_frz",  1, 1,  2,  1, 1, 0,13, 1, 0, 0, 1, 0, 3'b110, 3'b100, 3'b100);
        // Flush during load-use: stall still raised, bubble loads RF selects
        step("lw4_c",     1,12,  0,  1, 0, 1, 4, 1, 1, 0, 0, 0, 3'b110, 3'b000, 3'b100);
        step("add8_fl",   1, 4,  4,  1, 1, 0, 8, 1, 0, 1, 0, 1, 3'b100, 3'b100, 3'b100);
        step("lw4_d",     1, 4,  0,  1, 0, 1, 4, 1, 1, 0, 0, 0, 3'b101, 3'b000, 3'b100);

        // Reset asserted mid-stall, away from any clock edge
        id_valid = 1; id_rs1 = 5'd4; id_rs2 = 5'd4;
        id_use_rs1 = 1; id_use_rs2 = 1; id_use_imm = 0;
        id_rd = 5'd8; id_reg_write = 1; id_mem_read = 0;
        flush = 0; freeze = 0;
        #1;
        chk("pre_rst.stall", {2'b00, stall}, 3'b001);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst.stall", {2'b00, stall}, 3'b000);
        chk_sels("mid_rst", '{s1: 3'b100, s2: 3'b100, b: 3'b100});
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        step("post_rst",  1, 4,  4,  1, 1, 0, 8, 1, 0, 0, 0, 0, 3'b100, 3'b100, 3'b100);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control-side producer of the 3-bit select codes consumed by the EX-stage ALU source 1, ALU source 2 and branch-ALU source muxes.
- Keeps shadow copies of the destination-register info for each in-flight instruction (EX, MEM and WB slots).
- At each ID->EX advance, it computes and registers the forwarding selects so they line up with the instruction in EX.
- Also detects load-use hazards, stalls the front end and inserts a bubble.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 32, statistics counter width (optional feature only).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- freeze_i  in  1  global pipeline hold (memory wait); all state holds.
- flush_i  in  1  taken branch/jump; the ID instruction is squashed.
- id_valid_i  in  1  ID slot holds a real instruction.
- id_rs1_i  in  REG_ADDR_W  ID source 1 index.
- id_rs2_i  in  REG_ADDR_W  ID source 2 index.
- id_use_rs1_i  in  1  instruction reads rs1.
- id_use_rs2_i  in  1  instruction reads rs2.
- id_use_imm_i  in  1  ALU operand 2 is the immediate.
- id_rd_i  in  REG_ADDR_W  destination index.
- id_reg_write_i  in  1  instruction writes rd.
- id_mem_read_i  in  1  instruction is a load.
- stall_o  out  1  hold PC and IF/ID, bubble EX (combinational).
- ex_src1_sel_o  out  3  ALU source 1 select.
- ex_src2_sel_o  out  3  ALU source 2 select.
- ex_bsrc_sel_o  out  3  branch-ALU source select.

Behaviour:
- Select encoding is {use_reg, fwd_mem, fwd_wb}:
  - 3'b100 = register-file value
  - 3'b110 = MEM-stage forward
  - 3'b101 = WB-stage forward
  - 3'b000 = immediate (ex_src2_sel_o only)
- ex_src1_sel_o and ex_bsrc_sel_o never have bit 2 clear.
- ex_bsrc_sel_o uses rs2 with the same priority rules as src2, but ignores id_use_imm_i.
- Shadow slots EX, MEM and WB each hold {valid, rd, reg_write, mem_read}.
- On each non-frozen edge:
  - WB <= MEM
  - MEM <= EX
  - EX <= ID entry, or a bubble (valid=0) when stall_o or flush_i is asserted.
- Select computation at an advance:
  - For each source that is used and nonzero: if EX slot is valid, has reg_write and rd matches -> MEM forward, since that instruction is in MEM next cycle.
  - Otherwise, if MEM slot matches under the same conditions -> WB forward.
  - Otherwise -> 3'b100.
  - MEM beats WB when both match.
  - Index 0 is never forwarded.
  - An unused source gives 3'b100.
  - id_use_imm_i gives ex_src2_sel_o = 3'b000.
- Bubble or flush loads 3'b100 into all selects.
- Load-use: stall_o = id_valid_i & EX.valid & EX.mem_read & EX.rd!=0 & (rs1 used and equal, or rs2 used and equal).
  - This gives a one-cycle stall.
  - On the next cycle the load is in MEM, and the dependant's selects become WB forward.
- flush_i together with stall_o: flush wins; a bubble is inserted and stall_o is still driven. Front-end logic gives flush priority.
- freeze_i=1: no slot or select updates.
  - stall_o is still computed from the current state.
  - freeze_i overrides flush_i: flush_i is ignored while freeze_i=1.
- Reset, asynchronous at any time including mid-stall:
  - all slots are invalid
  - all selects are 3'b100
  - stall_o = 0 as a consequence
- Latency: one registered cycle from ID inputs to the select outputs.

Optional Feature:
- FWD_HAZARD_STATS_EN: adds CNT_W-bit output counters.
  - stat_fwd_mem_o: advances producing any MEM select.
  - stat_fwd_wb_o: advances producing any WB select.
  - stat_stall_o: cycles with stall_o=1 and freeze_i=0.
  - Counters saturate at all-ones and clear on RST.
- Without the macro, these ports and counters do not exist.

Test Plan:
- Back-to-back ALU ops: add x5,x1,x2 then sub x6,x5,x3 -> ex_src1_sel_o=3'b110, ex_src2_sel_o=3'b100, stall_o=0.
- One-instruction gap: add x5 ...; nop; or x7,x3,x5 -> ex_src2_sel_o=3'b101.
- Double match: add x5 twice in a row, then a reader of x5 -> MEM wins, 3'b110.
- Load-use: lw x4,0(x1) then add x8,x4,x4 -> stall_o=1 for exactly 1 cycle, bubble in EX, then src1=src2=3'b101.
- Load-use with immediate operand: lw x4,0(x1) then addi x9,x4,3 -> stall_o=1 for exactly 1 cycle, then src1=3'b101, src2=3'b000.
- Destination x0: addi x0,x0,1 then a reader of x0 -> 3'b100, no stall.
- Flush during load-use, plus reset: flush_i=1 while the load-use stall is active -> EX bubble, selects 3'b100. Then assert RST mid-stall -> all outputs reset immediately, without waiting for a clock.
